ppi_sync_ports: RTL and testbench
=================================

// Module: ppi_sync_ports
// PURPOSE
//  Clocked, parametrised successor of the 8255A-style PPI. Provides NUM_PORTS general-purpose ports
//  of PORT_W bits behind an 8-bit CPU bus. Each port is independently programmable as mode 0
//  (simple I/O) or mode 1 (strobed I/O with IBF/OBF/ACK handshake and interrupt).
//  Sits between the CPU bus decoder and off-chip peripherals. Tristates live in the pad ring.
// PARAMETERS
//  NUM_PORTS  4  number of ports; legal range 1..4
//  PORT_W     8  port width; legal range 4..8; bus reads are zero-extended to 8 bits
//  AW         3  address width; must satisfy 2**AW > NUM_PORTS
// PORTS
//  Clk     in   1                  system clock; all bus inputs are synchronous to Clk
//  nReset  in   1                  asynchronous, active-low reset
//  nCs     in   1                  chip select, active low
//  nRd     in   1                  read strobe, active low
//  nWr     in   1                  write strobe, active low
//  A       in   AW                 register address: A<NUM_PORTS selects a port; A==NUM_PORTS selects control/status
//  Din     in   8                  CPU write data
//  Dout    out  8                  CPU read data, registered
//  PortIn  in   NUM_PORTS*PORT_W   pin inputs, asynchronous
//  PortOut out  NUM_PORTS*PORT_W   output latches
//  PortOe  out  NUM_PORTS          per-port output enable; 1 = output direction
//  nStb    in   NUM_PORTS          mode-1 input strobe, asynchronous, active low
//  Ibf     out  NUM_PORTS          mode-1 input buffer full
//  nAck    in   NUM_PORTS          mode-1 output acknowledge, asynchronous, active low
//  nObf    out  NUM_PORTS          mode-1 output buffer full, active low
//  Intr    out  NUM_PORTS          per-port interrupt request
// BEHAVIOUR
//  Reset values: all ports mode 0, direction input, INTE=0.
//   PortOut=0, PortOe=0, Ibf=0, nObf=1, Intr=0, overrun=0, Dout=0.
//  Synchronisers: PortIn, nStb and nAck pass through 2-flop synchronisers (2-cycle latency).
//   Edges are detected on the synchronised copies.
//  Bus write: commits on the cycle where nCs=0 and nWr falls (nWr=0, previous cycle nWr=1).
//   A write is one event per strobe.
//  Bus read: same qualification on the falling edge of nRd. Dout is valid the cycle after.
//   The read "completes" on the rising edge of nRd.
//  Control write, Din[7]=1 (mode set):
//   - Din[5:4] selects the port; Din[1] is the mode; Din[0] is the direction (1=input);
//     Din[2] is INTE.
//   - Din[5:4] >= NUM_PORTS is ignored.
//   - Mode set clears that port's PortOut, Ibf, Intr and overrun, and sets nObf=1.
//  Status read (A==NUM_PORTS): Dout[3:0] = Intr, Dout[7:4] = overrun.
//   Unused bits read 0. Overrun bits clear on read completion.
//  Mode 0 input: port read returns the synchronised PortIn.
//  Mode 0 output: a port write updates PortOut; a port read returns PortOut.
//  Mode 1 input:
//   - Synced nStb falling while Ibf=0: PortIn is latched and Ibf=1.
//   - nStb rising with Ibf=1 and INTE=1: Intr=1.
//   - nStb falling while Ibf=1: latch is held and overrun[p]=1.
//   - Port read returns the latch; read completion clears Ibf and Intr.
//  Mode 1 output:
//   - CPU write: PortOut=Din, nObf=0, Intr=0 (all next cycle).
//   - nAck falling: nObf=1. nAck rising with INTE=1: Intr=1.
//   - A write while nObf=0 overwrites PortOut and nObf stays 0.
//  Simultaneous events:
//   - Read completion and an nStb fall in the same cycle: the strobe wins (new data latched, Ibf stays 1).
//   - Mode set and a handshake event in the same cycle: the mode set wins.
//   - A write to an input-mode port is ignored.
//  nReset assertion mid-handshake immediately forces all reset values.
// CONFIGURATION
//  PPI_BSR_EN defined: a control write with Din[7]=0 is bit set/reset.
//   - Din[5:4] selects the port, Din[3:1] the bit, Din[0] the value.
//   - Applies only to output-direction ports. A bit index >= PORT_W is ignored.
//   - Does not affect nObf or Intr.
//  PPI_BSR_EN undefined: a control write with Din[7]=0 is ignored.
// STRUCTURE
//  Package ppi_pkg: control-word bit positions, mode encodings (MODE0=0, MODE1=1),
//   direction encodings, and the status bit layout.
//  Sub-module ppi_port_chan (one per port, generate loop) contains:
//   synchronisers, edge detectors, the input latch, PortOut, Ibf/nObf/Intr/overrun,
//   and the mode/direction/INTE registers.
//  Top level holds bus edge detection, address decode and the Dout mux.
// TESTING
//  1. Reset while Intr=1 and nObf=0 -> all outputs at reset values asynchronously, before the next Clk edge.
//  2. Mode set port0 = 0x80|mode0|output, then write A=0 with 0xA5 -> PortOut[7:0]=0xA5, PortOe[0]=1;
//     read A=0 -> Dout=0xA5.
//  3. Port1 mode1 input with INTE; PortIn=0x3C; pulse nStb -> Ibf[1]=1 and Intr[1]=1 after nStb rises;
//     read -> Dout=0x3C; on nRd rise, Ibf=Intr=0.
//  4. Port1 second nStb pulse before read (PortIn=0x55) -> latch stays 0x3C; status read Dout[5]=1,
//     then 0 on the next status read.
//  5. Port2 mode1 output with INTE; write 0x7E -> nObf[2]=0; pulse nAck -> nObf=1, then Intr[2]=1
//     on nAck rise; next write clears Intr.
//  6. With PPI_BSR_EN: control 0x07 on port0 output -> PortOut[3]=1, other bits unchanged;
//     0x06 -> bit 3 cleared. Without the macro -> no change.

Source files
------------

// File: rtl/ppi_pkg.sv
// ppi_pkg: control-word bit positions, mode/direction encodings and status layout shared by the PPI.
package ppi_pkg;
  typedef enum logic {MODE0 = 1'b0, MODE1 = 1'b1} modeT;
  typedef enum logic {DIR_OUT = 1'b0, DIR_IN = 1'b1} dirT;
  localparam int cwModeSet = 7;
  localparam int cwPortHi = 5;
  localparam int cwPortLo = 4;
  localparam int cwBitHi = 3;
  localparam int cwBitLo = 1;
  localparam int cwInte = 2;
  localparam int cwMode = 1;
  localparam int cwDir = 0;
  localparam int cwBsrVal = 0;
  localparam int stIntrLo = 0;
  localparam int stOvrLo = 4;
  function automatic logic [7:0] statusWord(input logic [3:0] intr, input logic [3:0] ovr);
    return (8'(ovr) << stOvrLo) | (8'(intr) << stIntrLo);
  endfunction
endpackage

// File: rtl/ppi_sync_ports_if.sv
// ppi_sync_ports_if: CPU bus plus peripheral pins of the PPI; slave is the PPI side.
interface ppi_sync_ports_if #(parameter int NUM_PORTS = 4, parameter int PORT_W = 8, parameter int AW = 3);
  logic nCs;
  logic nRd;
  logic nWr;
  logic [AW-1:0] A;
  logic [7:0] Din;
  logic [7:0] Dout;
  logic [NUM_PORTS*PORT_W-1:0] PortIn;
  logic [NUM_PORTS*PORT_W-1:0] PortOut;
  logic [NUM_PORTS-1:0] PortOe;
  logic [NUM_PORTS-1:0] nStb;
  logic [NUM_PORTS-1:0] Ibf;
  logic [NUM_PORTS-1:0] nAck;
  logic [NUM_PORTS-1:0] nObf;
  logic [NUM_PORTS-1:0] Intr;
  modport master (output nCs, nRd, nWr, A, Din, PortIn, nStb, nAck,
                  input Dout, PortOut, PortOe, Ibf, nObf, Intr);
  modport slave (input nCs, nRd, nWr, A, Din, PortIn, nStb, nAck,
                 output Dout, PortOut, PortOe, Ibf, nObf, Intr);
endinterface

// File: rtl/ppi_port_chan.sv
// ppi_port_chan: one PPI port - pin synchronisers, strobe/ack edge detect, mode 0/1 data path and handshake flags.
module ppi_port_chan
  import ppi_pkg::*;
#(parameter int PORT_W = 8) (
  input  logic Clk,
  input  logic nReset,
  input  logic [PORT_W-1:0] pinIn,
  input  logic nStbPin,
  input  logic nAckPin,
  input  logic modeSet,
  input  modeT modeNew,
  input  dirT dirNew,
  input  logic inteNew,
  input  logic portWr,
  input  logic [PORT_W-1:0] wrData,
  input  logic rdDone,
  input  logic statClr,
  input  logic bsrWr,
  input  logic [2:0] bsrBit,
  input  logic bsrVal,
  output logic [PORT_W-1:0] portOut,
  output logic [PORT_W-1:0] rdData,
  output logic oe,
  output logic ibf,
  output logic nObf,
  output logic intr,
  output logic overrun
);
  modeT mode;
  dirT dir;
  logic inte, stbQ, ackQ, stbFall, stbRise, ackFall, ackRise, m1In, m1Out;
  logic [PORT_W-1:0] inS1, inS2, latch;
  logic [1:0] stbS, ackS;
  assign stbFall = stbQ && !stbS[1];
  assign stbRise = !stbQ && stbS[1];
  assign ackFall = ackQ && !ackS[1];
  assign ackRise = !ackQ && ackS[1];
  assign m1In = mode == MODE1 && dir == DIR_IN;
  assign m1Out = mode == MODE1 && dir == DIR_OUT;
  assign rdData = m1In ? latch : dir == DIR_IN ? inS2 : portOut;
  assign oe = dir == DIR_OUT;
  always_ff @(posedge Clk or negedge nReset)
    if (!nReset) begin
      inS1 <= '0;
      inS2 <= '0;
      stbS <= '1;
      ackS <= '1;
      stbQ <= 1'b1;
      ackQ <= 1'b1;
    end else begin
      inS1 <= pinIn;
      inS2 <= inS1;
      stbS <= {stbS[0], nStbPin};
      ackS <= {ackS[0], nAckPin};
      stbQ <= stbS[1];
      ackQ <= ackS[1];
    end
  // Later assignments win: a strobe beats a same-cycle read completion, a CPU write beats an ack.
  always_ff @(posedge Clk or negedge nReset)
    if (!nReset) begin
      mode <= MODE0;
      dir <= DIR_IN;
      inte <= 1'b0;
      latch <= '0;
      portOut <= '0;
      ibf <= 1'b0;
      nObf <= 1'b1;
      intr <= 1'b0;
      overrun <= 1'b0;
    end else if (modeSet) begin
      mode <= modeNew;
      dir <= dirNew;
      inte <= inteNew;
      portOut <= '0;
      ibf <= 1'b0;
      nObf <= 1'b1;
      intr <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (statClr) overrun <= 1'b0;
      if (m1In) begin
        if (rdDone) begin
          ibf <= 1'b0;
          intr <= 1'b0;
        end
        if (stbFall && ibf && !rdDone) overrun <= 1'b1;
        else if (stbFall) begin
          latch <= inS2;
          ibf <= 1'b1;
        end
        if (stbRise && ibf && !rdDone && inte) intr <= 1'b1;
      end
      if (m1Out) begin
        if (ackFall) nObf <= 1'b1;
        if (ackRise && inte) intr <= 1'b1;
      end
      if (portWr && dir == DIR_OUT) begin
        portOut <= wrData;
        if (mode == MODE1) begin
          nObf <= 1'b0;
          intr <= 1'b0;
        end
      end
      if (bsrWr && dir == DIR_OUT) portOut[bsrBit] <= bsrVal;
    end
endmodule

// File: rtl/ppi_sync_ports.sv
// ppi_sync_ports: clocked 8255A-style PPI; bus strobe edge detect, address decode, registered read mux.
// Optional bit set/reset control writes are enabled by defining PPI_BSR_EN.
module ppi_sync_ports
  import ppi_pkg::*;
#(parameter int NUM_PORTS = 4, parameter int PORT_W = 8, parameter int AW = 3) (
  input logic Clk,
  input logic nReset,
  ppi_sync_ports_if.slave bus
);
  localparam logic [AW-1:0] ctlAddr = AW'(NUM_PORTS);
  logic nWrQ, nRdQ, rdPend, wrEv, rdEv, rdDone, ctlWr, modeSetAll, bsrAll;
  logic [AW-1:0] rdAddr;
  logic [PORT_W-1:0] rdData [NUM_PORTS];
  logic [PORT_W-1:0] portRd;
  logic [NUM_PORTS*PORT_W-1:0] portOutV;
  logic [NUM_PORTS-1:0] oeV, ibfV, nObfV, intrV, ovrV;
  assign wrEv = !bus.nCs && !bus.nWr && nWrQ;
  assign rdEv = !bus.nCs && !bus.nRd && nRdQ;
  assign rdDone = rdPend && bus.nRd && !nRdQ;
  assign ctlWr = wrEv && bus.A == ctlAddr;
  assign modeSetAll = ctlWr && bus.Din[cwModeSet];
`ifdef PPI_BSR_EN
  assign bsrAll = ctlWr && !bus.Din[cwModeSet] && 32'(bus.Din[cwBitHi:cwBitLo]) < PORT_W;
`else
  assign bsrAll = 1'b0;
`endif
  for (genvar p = 0; p < NUM_PORTS; p++) begin : gChan
    ppi_port_chan #(.PORT_W(PORT_W)) uChan (
      .Clk(Clk),
      .nReset(nReset),
      .pinIn(bus.PortIn[p*PORT_W +: PORT_W]),
      .nStbPin(bus.nStb[p]),
      .nAckPin(bus.nAck[p]),
      .modeSet(modeSetAll && bus.Din[cwPortHi:cwPortLo] == 2'(p)),
      .modeNew(modeT'(bus.Din[cwMode])),
      .dirNew(dirT'(bus.Din[cwDir])),
      .inteNew(bus.Din[cwInte]),
      .portWr(wrEv && bus.A == AW'(p)),
      .wrData(bus.Din[PORT_W-1:0]),
      .rdDone(rdDone && rdAddr == AW'(p)),
      .statClr(rdDone && rdAddr == ctlAddr),
      .bsrWr(bsrAll && bus.Din[cwPortHi:cwPortLo] == 2'(p)),
      .bsrBit(bus.Din[cwBitHi:cwBitLo]),
      .bsrVal(bus.Din[cwBsrVal]),
      .portOut(portOutV[p*PORT_W +: PORT_W]),
      .rdData(rdData[p]),
      .oe(oeV[p]),
      .ibf(ibfV[p]),
      .nObf(nObfV[p]),
      .intr(intrV[p]),
      .overrun(ovrV[p])
    );
  end
  assign bus.PortOut = portOutV;
  assign bus.PortOe = oeV;
  assign bus.Ibf = ibfV;
  assign bus.nObf = nObfV;
  assign bus.Intr = intrV;
  always_comb begin
    portRd = '0;
    for (int i = 0; i < NUM_PORTS; i++) if (bus.A == AW'(i)) portRd = rdData[i];
  end
  // The read address is held so side effects land on the nRd rising edge.
  always_ff @(posedge Clk or negedge nReset)
    if (!nReset) begin
      nWrQ <= 1'b1;
      nRdQ <= 1'b1;
      rdPend <= 1'b0;
      rdAddr <= '0;
      bus.Dout <= '0;
    end else begin
      nWrQ <= bus.nWr;
      nRdQ <= bus.nRd;
      rdPend <= rdEv ? 1'b1 : rdDone ? 1'b0 : rdPend;
      if (rdEv) begin
        rdAddr <= bus.A;
        bus.Dout <= bus.A < ctlAddr ? 8'(portRd) : bus.A == ctlAddr ? statusWord(4'(intrV), 4'(ovrV)) : 8'h00;
      end
    end
endmodule

// File: tb/tb_ppi_sync_ports.sv
// tb_ppi_sync_ports: table-driven mode-0 vectors plus hand-written handshake, BSR and async reset sequences.
module tb_ppi_sync_ports;
  localparam int NP = 4;
  localparam int PW = 8;
  localparam int AW = 3;
`ifdef PPI_BSR_EN
  localparam logic [7:0] bsrSetExp = 8'h5A;
`else
  localparam logic [7:0] bsrSetExp = 8'h52;
`endif
  typedef struct {
    logic wr;
    logic [AW-1:0] a;
    logic [7:0] d;
  } vecT;
  logic Clk = 1'b0;
  logic nReset = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [7:0] expQ[$];
  vecT vec[16];
  always #5 Clk = ~Clk;
  ppi_sync_ports_if #(.NUM_PORTS(NP), .PORT_W(PW), .AW(AW)) bus ();
  ppi_sync_ports #(.NUM_PORTS(NP), .PORT_W(PW), .AW(AW)) dut (.Clk(Clk), .nReset(nReset), .bus(bus));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic busWrite(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge Clk);
    bus.nCs = 1'b0;
    bus.A = a;
    bus.Din = d;
    bus.nWr = 1'b0;
    @(negedge Clk);
    bus.nWr = 1'b1;
    bus.nCs = 1'b1;
    @(negedge Clk);
  endtask
  task automatic busRead(input logic [AW-1:0] a, input logic [7:0] exp, input string name);
    expQ.push_back(exp);
    @(negedge Clk);
    bus.nCs = 1'b0;
    bus.A = a;
    bus.nRd = 1'b0;
    @(negedge Clk);
    if (expQ.size() == 0) chk({name, " scoreboard empty"}, 32'd1, 32'd0);
    else chk(name, {24'd0, bus.Dout}, {24'd0, expQ.pop_front()});
    bus.nRd = 1'b1;
    @(negedge Clk);
    bus.nCs = 1'b1;
  endtask
  task automatic strobe(input int p);
    bus.nStb[p] = 1'b0;
    repeat (4) @(negedge Clk);
    bus.nStb[p] = 1'b1;
    repeat (4) @(negedge Clk);
  endtask
  initial begin
    vec[0] = '{1'b1, 3'd4, 8'h80};
    vec[1] = '{1'b1, 3'd0, 8'hA5};
    vec[2] = '{1'b0, 3'd0, 8'hA5};
    vec[3] = '{1'b1, 3'd4, 8'hB1};
    vec[4] = '{1'b0, 3'd3, 8'h9A};
    vec[5] = '{1'b1, 3'd3, 8'hFF};
    vec[6] = '{1'b0, 3'd3, 8'h9A};
    vec[7] = '{1'b1, 3'd5, 8'h77};
    vec[8] = '{1'b0, 3'd5, 8'h00};
    vec[9] = '{1'b0, 3'd0, 8'hA5};
    vec[10] = '{1'b1, 3'd0, 8'h3C};
    vec[11] = '{1'b0, 3'd0, 8'h3C};
    vec[12] = '{1'b1, 3'd4, 8'h80};
    vec[13] = '{1'b0, 3'd0, 8'h00};
    vec[14] = '{1'b1, 3'd0, 8'h52};
    vec[15] = '{1'b0, 3'd4, 8'h00};
    bus.nCs = 1'b1;
    bus.nRd = 1'b1;
    bus.nWr = 1'b1;
    bus.A = '0;
    bus.Din = '0;
    bus.PortIn = 32'h9A553C11;
    bus.nStb = '1;
    bus.nAck = '1;
    repeat (2) @(negedge Clk);
    chk("rst PortOut", bus.PortOut, 0);
    chk("rst PortOe", {28'd0, bus.PortOe}, 0);
    chk("rst Ibf", {28'd0, bus.Ibf}, 0);
    chk("rst nObf", {28'd0, bus.nObf}, 32'hF);
    chk("rst Intr", {28'd0, bus.Intr}, 0);
    chk("rst Dout", {24'd0, bus.Dout}, 0);
    nReset = 1'b1;
    repeat (2) @(negedge Clk);
    for (int i = 0; i < 16; i++)
      if (vec[i].wr) busWrite(vec[i].a, vec[i].d);
      else busRead(vec[i].a, vec[i].d, $sformatf("vec%0d read", i));
    chk("mode0 PortOut", {24'd0, bus.PortOut[7:0]}, 32'h52);
    chk("mode0 PortOe", {28'd0, bus.PortOe}, 32'h1);
    busWrite(3'd4, 8'h97);
    bus.nStb[1] = 1'b0;
    repeat (4) @(negedge Clk);
    chk("m1in Ibf set", {31'd0, bus.Ibf[1]}, 1);
    chk("m1in Intr before rise", {31'd0, bus.Intr[1]}, 0);
    bus.nStb[1] = 1'b1;
    repeat (4) @(negedge Clk);
    chk("m1in Intr after rise", {31'd0, bus.Intr[1]}, 1);
    busRead(3'd1, 8'h3C, "m1in read");
    chk("m1in Ibf clr", {31'd0, bus.Ibf[1]}, 0);
    chk("m1in Intr clr", {31'd0, bus.Intr[1]}, 0);
    strobe(1);
    bus.PortIn[15:8] = 8'h55;
    repeat (3) @(negedge Clk);
    strobe(1);
    busRead(3'd4, 8'h22, "status overrun");
    busRead(3'd4, 8'h02, "status overrun cleared");
    busRead(3'd1, 8'h3C, "latch held");
    busRead(3'd4, 8'h00, "status idle");
    busWrite(3'd4, 8'hA6);
    chk("m1out PortOe", {28'd0, bus.PortOe}, 32'h5);
    chk("m1out nObf idle", {31'd0, bus.nObf[2]}, 1);
    busWrite(3'd2, 8'h7E);
    chk("m1out nObf low", {31'd0, bus.nObf[2]}, 0);
    chk("m1out PortOut", {24'd0, bus.PortOut[23:16]}, 32'h7E);
    bus.nAck[2] = 1'b0;
    repeat (4) @(negedge Clk);
    chk("m1out nObf ack", {31'd0, bus.nObf[2]}, 1);
    chk("m1out Intr before rise", {31'd0, bus.Intr[2]}, 0);
    bus.nAck[2] = 1'b1;
    repeat (4) @(negedge Clk);
    chk("m1out Intr after rise", {31'd0, bus.Intr[2]}, 1);
    busRead(3'd2, 8'h7E, "m1out read");
    busWrite(3'd2, 8'h81);
    chk("m1out Intr clr", {31'd0, bus.Intr[2]}, 0);
    chk("m1out nObf rewrite", {31'd0, bus.nObf[2]}, 0);
    busWrite(3'd2, 8'h42);
    chk("m1out overwrite nObf", {31'd0, bus.nObf[2]}, 0);
    chk("m1out overwrite data", {24'd0, bus.PortOut[23:16]}, 32'h42);
    busWrite(3'd4, 8'h07);
    chk("bsr set", {24'd0, bus.PortOut[7:0]}, {24'd0, bsrSetExp});
    busWrite(3'd4, 8'h06);
    chk("bsr clr", {24'd0, bus.PortOut[7:0]}, 32'h52);
    busWrite(3'd4, 8'h31);
    chk("bsr input port", {24'd0, bus.PortOut[31:24]}, 0);
    chk("bsr nObf", {31'd0, bus.nObf[2]}, 0);
    strobe(1);
    chk("pre-reset Intr", {31'd0, bus.Intr[1]}, 1);
    @(negedge Clk);
    #2 nReset = 1'b0;
    #1;
    chk("async rst PortOut", bus.PortOut, 0);
    chk("async rst PortOe", {28'd0, bus.PortOe}, 0);
    chk("async rst Ibf", {28'd0, bus.Ibf}, 0);
    chk("async rst nObf", {28'd0, bus.nObf}, 32'hF);
    chk("async rst Intr", {28'd0, bus.Intr}, 0);
    chk("async rst Dout", {24'd0, bus.Dout}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
